// File: rtl/wall_controller_pkg.sv
// Shared constants for the wall sequencer: datapath state codes, FSM encoding,
// screen geometry, colours and the LFSR step used to place the gap.
package wall_pkg;

  localparam logic [1:0] CS_UPDATE = 2'd0;
  localparam logic [1:0] CS_HOLD   = 2'd1;
  localparam logic [1:0] CS_ERASE  = 2'd2;
  localparam logic [1:0] CS_DRAW   = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ERASE  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DRAW   = 3'd4;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] WALL_COLOUR  = 3'b010;
  localparam logic [2:0] ERASE_COLOUR = 3'b000;

  localparam logic [7:0] LFSR_SEED    = 8'hA5;
  localparam logic [6:0] HOLE_Y_RESET = 7'd35;
  localparam logic [7:0] WRAP_LIMIT   = 8'd4;

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_step(input logic [7:0] value);
    return {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
  endfunction

endpackage

// File: rtl/wall_controller_if.sv
// Signal bundle between the wall sequencer, the game top-level, datapath_wall
// and the VGA adapter.
interface wall_controller_if;

  logic       start;
  logic       game_over;
  logic [7:0] wall_x;
  logic [1:0] cur_state;
  logic       plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic [6:0] hole_y;
  logic       busy;

  modport master (
    input  start, game_over, wall_x,
    output cur_state, plot, x_out, y_out, colour, hole_y, busy
  );

  modport slave (
    output start, game_over, wall_x,
    input  cur_state, plot, x_out, y_out, colour, hole_y, busy
  );

endinterface

// File: rtl/wall_controller_frame_divider.sv
// Frame tick generator: counts clk cycles while not cleared and pulses tick on
// the last cycle of each FRAME_DIV-cycle period.
module frame_divider #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = !clear && (count == CW'(FRAME_DIV - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/wall_controller.sv
// Per-frame wall sequencer: erase the old column, pulse the datapath update for
// one cycle, then redraw the wall with its gap, one pixel per cycle.
module wall_controller
  import wall_pkg::*;
#(
  parameter int FRAME_DIV   = 833333,
  parameter int WALL_WIDTH  = 4,
  parameter int WALL_HEIGHT = 120,
  parameter int HOLE_HEIGHT = 50
) (
  input logic              clk,
  input logic              resetn,
  wall_controller_if.master bus
);

  localparam int DXW = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
  localparam int DYW = (WALL_HEIGHT > 1) ? $clog2(WALL_HEIGHT) : 1;

  logic [2:0]     state;
  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;
  logic [7:0]     lfsr;
  logic [6:0]     hole_y;
  logic           tick;
  logic           dx_last;
  logic           dy_last;
  logic [7:0]     x_sum;
  logic [8:0]     dy_ext;
  logic [8:0]     hole_lo;
  logic           on_screen;
  logic           in_hole;

  frame_divider #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_divider (
    .clk   (clk),
    .resetn(resetn),
    .clear (state != S_WAIT),
    .tick  (tick)
  );

  assign dx_last   = (dx == DXW'(WALL_WIDTH - 1));
  assign dy_last   = (dy == DYW'(WALL_HEIGHT - 1));
  assign x_sum     = bus.wall_x + 8'(dx);
  assign dy_ext    = 9'(dy);
  assign hole_lo   = {2'b00, hole_y};
  assign on_screen = (x_sum < 8'(SCREEN_W));
  assign in_hole   = (dy_ext >= hole_lo) && (dy_ext < hole_lo + 9'(HOLE_HEIGHT));

  // Counters keep walking when plot is suppressed so each pass is a fixed W*H cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      dx     <= '0;
      dy     <= '0;
      lfsr   <= LFSR_SEED;
      hole_y <= HOLE_Y_RESET;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.game_over) state <= S_IDLE;
          else if (tick)     state <= S_ERASE;
        end
        S_ERASE, S_DRAW: begin
          if (dx_last) begin
            dx <= '0;
            if (dy_last) begin
              dy    <= '0;
              state <= (state == S_ERASE) ? S_UPDATE : S_WAIT;
            end else begin
              dy <= dy + DYW'(1);
            end
          end else begin
            dx <= dx + DXW'(1);
          end
        end
        S_UPDATE: begin
          if (bus.wall_x < WRAP_LIMIT) begin
            lfsr   <= lfsr_step(lfsr);
            hole_y <= {1'b0, lfsr[5:0]} + 7'd4;
          end
          state <= S_DRAW;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cur_state = CS_HOLD;
    bus.plot      = 1'b0;
    bus.x_out     = 8'd0;
    bus.y_out     = 7'd0;
    bus.colour    = ERASE_COLOUR;
    bus.busy      = 1'b0;
    bus.hole_y    = hole_y;
    case (state)
      S_ERASE: begin
        bus.cur_state = CS_ERASE;
        bus.x_out     = x_sum;
        bus.y_out     = 7'(dy);
        bus.plot      = on_screen;
        bus.busy      = 1'b1;
      end
      S_UPDATE: begin
        bus.cur_state = CS_UPDATE;
        bus.busy      = 1'b1;
      end
      S_DRAW: begin
        bus.cur_state = CS_DRAW;
        bus.x_out     = x_sum;
        bus.y_out     = 7'(dy);
        bus.colour    = WALL_COLOUR;
        bus.plot      = on_screen && !in_hole;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wall_controller.md
Name: wall_controller

Overview:
Sequencer for the wall datapath on the 160x120 VGA playfield. Once per frame tick it erases the wall column at its current x, strobes the datapath into its UPDATE_WALL state for exactly one cycle, then redraws the wall with a gap at a pseudo-random height. It emits pixel plot requests (x, y, colour, plot) to the VGA adapter and sits between the game top-level (start/game_over) and datapath_wall.

Parameters:
FRAME_DIV, 833333, clk cycles per frame tick (50 MHz / 60 Hz).
WALL_WIDTH, 4, wall thickness in pixels (power of two).
WALL_HEIGHT, 120, wall height in pixels, starting at y=0.
HOLE_HEIGHT, 50, gap height in pixels.
SCREEN_W, 160, first x column that is off-screen.
WALL_COLOUR, 3'b010, draw colour. Erase colour is 3'b000.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  level; leaves IDLE
game_over  in  1  level; returns to IDLE at the next WAIT
wall_x  in  8  current wall x from datapath_wall
cur_state  out  2  state code to datapath_wall
plot  out  1  pixel write strobe
x_out  out  8  pixel x
y_out  out  7  pixel y
colour  out  3  pixel colour
hole_y  out  7  top row of the current gap
busy  out  1  high in ERASE, UPDATE and DRAW

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on resetn.
- Reset values: state IDLE, frame counter 0, dx 0, dy 0, plot 0, colour 0, x_out 0, y_out 0, busy 0, hole_y 35, LFSR 8'hA5, cur_state HOLD.
- cur_state encoding:
  - UPDATE = 2'd0 (fixed by the datapath)
  - HOLD = 1
  - ERASE = 2
  - DRAW = 3
  - IDLE and WAIT both drive HOLD.
  - UPDATE is driven only in S_UPDATE.
- FSM transitions:
  - S_IDLE -> S_WAIT when start=1. The frame counter clears on entry.
  - S_WAIT:
    - The counter increments each cycle.
    - If game_over=1, go to S_IDLE; this takes priority over the tick.
    - Otherwise, when the counter reaches FRAME_DIV-1, clear it and go to S_ERASE.
  - S_ERASE: walks dx 0..WALL_WIDTH-1 as the inner loop and dy 0..WALL_HEIGHT-1 as the outer loop, one pixel per cycle, colour 0. After the last pixel (dx=W-1, dy=H-1), clear the counters and go to S_UPDATE.
  - S_UPDATE: lasts exactly one cycle with cur_state=0. If wall_x < 4, the wall wraps on this update, so:
    - the LFSR advances (taps 8,6,5,4)
    - hole_y <= {1'b0, lfsr[5:0]} + 4, giving a range of 4..67 so the gap always fits inside 120 rows.
    Then go to S_DRAW.
  - S_DRAW: same walk as ERASE, colour WALL_COLOUR, using the wall_x value after the update. When done, go to S_WAIT.
- Pixel outputs: combinational from the state and counters, in the same cycle as the counter value.
  - x_out = wall_x + dx (8-bit; wall_x ≤ 160 so there is no overflow).
  - y_out = dy.
- plot rules:
  - plot = 1 in ERASE and DRAW only.
  - plot is forced to 0 when x_out ≥ SCREEN_W.
  - In DRAW only, plot is also forced to 0 when hole_y ≤ dy < hole_y+HOLE_HEIGHT.
  - The counters still advance when plot is suppressed, so every pass is exactly W*H cycles.
- Timing: frame period = FRAME_DIV cycles in WAIT + 2*W*H + 1 cycles of work (961 with defaults).
- Mid-pass events:
  - game_over and start are ignored during ERASE/UPDATE/DRAW; the pass always completes.
  - resetn low at any time forces the reset values immediately.

Decomposition:
- Package wall_pkg holds:
  - cur_state codes
  - FSM state encoding
  - SCREEN_W / SCREEN_H
  - colour constants
- Sub-module frame_divider (parameter FRAME_DIV; ports clk, resetn, clear, tick) owns the WAIT counter. The pixel walk and LFSR stay in wall_controller.

Test Plan:
- Reset, then start=1 with FRAME_DIV=10 -> cur_state=1 and plot=0 for 10 cycles, then 480 plot cycles at colour 0 with x_out=160..163 suppressed (wall_x=160), then exactly one cycle of cur_state=0.
- wall_x=40, hole_y=35, DRAW pass -> plots at y 0..34 and 85..119 for x 40..43 (280 plots), none at y 35..84.
- wall_x=2 at S_UPDATE -> hole_y changes to lfsr[5:0]+4 on the next cycle; with wall_x=8 at S_UPDATE -> hole_y unchanged.
- game_over=1 asserted mid-DRAW -> DRAW completes all 480 cycles, enters WAIT, then goes to IDLE on the next cycle; no further cur_state=0.
- resetn pulsed low mid-ERASE at dy=50 -> plot drops to 0 asynchronously, state IDLE, hole_y=35, counters 0.
- Run 100 frames with the datapath model -> hole_y always within 4..67, and exactly one cur_state=0 cycle per frame.
